// File: rtl/frog_move_ctrl_pkg.sv
// Shared types for the frog movement controller: FSM state encoding,
// button/direction index constants and the direction priority encoder.
package frog_move_ctrl_pkg;

    localparam int unsigned SW_W  = 4;
    localparam int unsigned DIR_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_LOCK   = 2'd3
    } state_e;

    localparam logic [DIR_W-1:0] DIR_UP    = 2'd0;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd1;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd2;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd3;

    localparam logic [SW_W-1:0] SW_NONE = 4'b0000;
    localparam logic [SW_W-1:0] SW_ALL  = 4'b1111;

    // Highest-priority pressed direction: Up > Down > Left > Right.
    function automatic logic [DIR_W-1:0] prio_dir(input logic [SW_W-1:0] sw);
        if (sw[DIR_UP])
            return DIR_UP;
        else if (sw[DIR_DOWN])
            return DIR_DOWN;
        else if (sw[DIR_LEFT])
            return DIR_LEFT;
        else
            return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/frog_move_ctrl_repeat_timer.sv
// Auto-repeat counter with terminal-count compare; the limit is the initial
// hold delay or the repeat period depending on sel_period.
module repeat_timer #(
    parameter int unsigned DELAY_LEN  = 10,
    parameter int unsigned PERIOD_LEN = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic sel_period,
    output logic tc_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = clr ? '0 : count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign tc_c = (count_q == (sel_period ? CNT_W'(PERIOD_LEN - 1)
                                          : CNT_W'(DELAY_LEN - 1)));

endmodule

// File: rtl/frog_move_ctrl.sv
// Button-to-move pulse controller with start detection and hold-to-repeat.
// Auto-repeat (DELAY/REPEAT states + repeat_timer) is built only when
// FROG_MOVE_AUTOREPEAT_EN is defined; otherwise each press gives one pulse.
module frog_move_ctrl
    import frog_move_ctrl_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 12_500_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [3:0] i_Switches,
    output logic       o_Up_Mvt,
    output logic       o_Down_Mvt,
    output logic       o_Left_Mvt,
    output logic       o_Right_Mvt,
    output logic       o_Game_Start,
    output logic       o_Busy
);

    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
        $error("frog_move_ctrl: REPEAT_DELAY and REPEAT_PERIOD must both be >= 2");
    end

    state_e             state_q, state_d;
    logic [DIR_W-1:0]   dir_q, dir_d;
    logic [SW_W-1:0]    mvt_q, mvt_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic [DIR_W-1:0]   press_dir_c;

    assign press_dir_c = prio_dir(i_Switches);

`ifdef FROG_MOVE_AUTOREPEAT_EN
    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    logic cnt_clr_c;
    logic tm_tc_c;
    logic latched_held_c;

    assign latched_held_c = i_Switches[dir_q];

    repeat_timer #(
        .DELAY_LEN  (REPEAT_DELAY),
        .PERIOD_LEN (REPEAT_PERIOD),
        .CNT_W      (CNT_W)
    ) u_repeat_timer (
        .clk        (i_Clk),
        .rst        (i_Reset),
        .clr        (cnt_clr_c),
        .sel_period (state_q == ST_REPEAT),
        .tc_c       (tm_tc_c)
    );
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_UP;
            mvt_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            mvt_q   <= mvt_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

    // Next state and next pulse values; at most one pulse bit is set per cycle.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        mvt_d   = '0;
        start_d = 1'b0;
`ifdef FROG_MOVE_AUTOREPEAT_EN
        cnt_clr_c = 1'b1;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_Switches == SW_ALL) begin
                    start_d = 1'b1;
                    state_d = ST_LOCK;
                end else if (i_Switches != SW_NONE) begin
                    dir_d              = press_dir_c;
                    mvt_d[press_dir_c] = 1'b1;
`ifdef FROG_MOVE_AUTOREPEAT_EN
                    state_d = ST_DELAY;
`else
                    state_d = ST_LOCK;
`endif
                end
            end
`ifdef FROG_MOVE_AUTOREPEAT_EN
            ST_DELAY, ST_REPEAT: begin
                cnt_clr_c = 1'b0;
                if (i_Switches == SW_ALL) begin
                    start_d   = 1'b1;
                    state_d   = ST_LOCK;
                    cnt_clr_c = 1'b1;
                end else if (!latched_held_c) begin
                    state_d   = (i_Switches == SW_NONE) ? ST_IDLE : ST_LOCK;
                    cnt_clr_c = 1'b1;
                end else if (tm_tc_c) begin
                    mvt_d[dir_q] = 1'b1;
                    state_d      = ST_REPEAT;
                    cnt_clr_c    = 1'b1;
                end
            end
`endif
            ST_LOCK: begin
                if (i_Switches == SW_NONE)
                    state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign o_Up_Mvt     = mvt_q[DIR_UP];
    assign o_Down_Mvt   = mvt_q[DIR_DOWN];
    assign o_Left_Mvt   = mvt_q[DIR_LEFT];
    assign o_Right_Mvt  = mvt_q[DIR_RIGHT];
    assign o_Game_Start = start_q;
    assign o_Busy       = busy_q;

endmodule

// File: tb/tb_frog_move_ctrl.sv
// Self-checking bench for frog_move_ctrl (REPEAT_DELAY=10, REPEAT_PERIOD=4);
// expectations follow FROG_MOVE_AUTOREPEAT_EN the same way the RTL does.
module tb_frog_move_ctrl;

    localparam int unsigned RD = 10;
    localparam int unsigned RP = 4;

    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_UP   = 5'b00001;
    localparam logic [4:0] P_DN   = 5'b00010;
    localparam logic [4:0] P_LT   = 5'b00100;
    localparam logic [4:0] P_RT   = 5'b01000;
    localparam logic [4:0] P_ST   = 5'b10000;

    typedef struct packed {
        logic [4:0] pulse;
        logic       busy;
    } exp_t;

    typedef struct {
        logic [3:0] sw;
        logic [4:0] ep;
        logic       eb;
    } vec_t;

    logic       clk;
    logic       i_Reset;
    logic [3:0] i_Switches;
    logic       o_Up_Mvt, o_Down_Mvt, o_Left_Mvt, o_Right_Mvt, o_Game_Start, o_Busy;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    frog_move_ctrl #(
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .i_Clk        (clk),
        .i_Reset      (i_Reset),
        .i_Switches   (i_Switches),
        .o_Up_Mvt     (o_Up_Mvt),
        .o_Down_Mvt   (o_Down_Mvt),
        .o_Left_Mvt   (o_Left_Mvt),
        .o_Right_Mvt  (o_Right_Mvt),
        .o_Game_Start (o_Game_Start),
        .o_Busy       (o_Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected pulse for step i of a held press (i=0 is the press cycle).
    function automatic logic rep_pulse(input int i);
        if (i == 0)
            return 1'b1;
`ifdef FROG_MOVE_AUTOREPEAT_EN
        if (i >= int'(RD) && ((i - int'(RD)) % int'(RP)) == 0)
            return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic add_vec(input logic [3:0] sw, input logic [4:0] ep, input logic eb);
        vec_t v;
        v.sw = sw;
        v.ep = ep;
        v.eb = eb;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, queue its expected outputs, then compare after the edge.
    task automatic step(input logic rst, input logic [3:0] sw, input logic [4:0] ep,
                        input logic eb, input string name);
        exp_t e;
        exp_t got;
        i_Reset    = rst;
        i_Switches = sw;
        e.pulse    = ep;
        e.busy     = eb;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got.pulse = {o_Game_Start, o_Right_Mvt, o_Left_Mvt, o_Down_Mvt, o_Up_Mvt};
        got.busy  = o_Busy;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got pulse=%b busy=%b", name, got.pulse, got.busy);
        end else begin
            e = sb_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL %s @%0t: got pulse=%b busy=%b, expected pulse=%b busy=%b",
                         name, $time, got.pulse, got.busy, e.pulse, e.busy);
            end
        end
    endtask

    initial begin
        i_Reset    = 1'b1;
        i_Switches = 4'b0000;

        // Short sequences: priority encoding, start, release-to-lock rules.
        add_vec(4'b0000, P_NONE, 1'b0);
        add_vec(4'b0110, P_DN,   1'b1);
        add_vec(4'b0110, P_NONE, 1'b1);
        add_vec(4'b0000, P_NONE, 1'b0);
        add_vec(4'b1000, P_RT,   1'b1);
        add_vec(4'b0000, P_NONE, 1'b0);
        add_vec(4'b0100, P_LT,   1'b1);
        add_vec(4'b0000, P_NONE, 1'b0);
        add_vec(4'b1111, P_ST,   1'b1);
        add_vec(4'b1111, P_NONE, 1'b1);
        add_vec(4'b0111, P_NONE, 1'b1);
        add_vec(4'b0000, P_NONE, 1'b0);
        add_vec(4'b0010, P_DN,   1'b1);
`ifdef FROG_MOVE_AUTOREPEAT_EN
        add_vec(4'b1111, P_ST,   1'b1);
`else
        add_vec(4'b1111, P_NONE, 1'b1);
`endif
        add_vec(4'b0000, P_NONE, 1'b0);
        add_vec(4'b1010, P_DN,   1'b1);
        add_vec(4'b1000, P_NONE, 1'b1);
        add_vec(4'b1000, P_NONE, 1'b1);
        add_vec(4'b0000, P_NONE, 1'b0);
        add_vec(4'b0001, P_UP,   1'b1);
        add_vec(4'b0011, P_NONE, 1'b1);
        add_vec(4'b0010, P_NONE, 1'b1);
        add_vec(4'b0000, P_NONE, 1'b0);

        step(1'b1, 4'b0000, P_NONE, 1'b0, "reset");
        step(1'b1, 4'b1111, P_NONE, 1'b0, "reset_held");
        step(1'b0, 4'b0000, P_NONE, 1'b0, "idle");

        foreach (vecs[k])
            step(1'b0, vecs[k].sw, vecs[k].ep, vecs[k].eb, $sformatf("vec%0d", k));

        // Up held 30 cycles, then released.
        for (int i = 0; i < 30; i++)
            step(1'b0, 4'b0001, rep_pulse(i) ? P_UP : P_NONE, 1'b1, $sformatf("up_hold%0d", i));
        step(1'b0, 4'b0000, P_NONE, 1'b0, "up_release");

        // Left, Right added two cycles later: only Left pulses; then Left released.
        for (int i = 0; i < 20; i++)
            step(1'b0, (i < 2) ? 4'b0100 : 4'b1100, rep_pulse(i) ? P_LT : P_NONE, 1'b1,
                 $sformatf("left_hold%0d", i));
        for (int i = 0; i < 5; i++)
            step(1'b0, 4'b1000, P_NONE, 1'b1, $sformatf("right_lock%0d", i));
        step(1'b0, 4'b0000, P_NONE, 1'b0, "right_release");

        // All four pressed together and held 50 cycles.
        for (int i = 0; i < 50; i++)
            step(1'b0, 4'b1111, (i == 0) ? P_ST : P_NONE, 1'b1, $sformatf("start_hold%0d", i));
        step(1'b0, 4'b0000, P_NONE, 1'b0, "start_release");

        // Down and Right together held 30 cycles.
        for (int i = 0; i < 30; i++)
            step(1'b0, 4'b1010, rep_pulse(i) ? P_DN : P_NONE, 1'b1, $sformatf("down_hold%0d", i));
        step(1'b0, 4'b0000, P_NONE, 1'b0, "down_release");

        // Reset during a held Up press aborts; release with Up held is a fresh press.
        for (int i = 0; i < 8; i++)
            step(1'b0, 4'b0001, rep_pulse(i) ? P_UP : P_NONE, 1'b1, $sformatf("rst_pre%0d", i));
        for (int i = 8; i < 11; i++)
            step(1'b1, 4'b0001, P_NONE, 1'b0, $sformatf("rst_mid%0d", i));
        for (int i = 11; i < 23; i++)
            step(1'b0, 4'b0001, rep_pulse(i - 11) ? P_UP : P_NONE, 1'b1,
                 $sformatf("rst_post%0d", i));
        step(1'b0, 4'b0000, P_NONE, 1'b0, "rst_release");

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frog_move_ctrl.md
FROG_MOVE_CTRL -- requirements
Module: frog_move_ctrl

Interface
REQ-001 Parameter REPEAT_DELAY, default 12_500_000, clocks a direction is held before auto-repeat begins (0.5 s at 25 MHz).
REQ-002 Parameter REPEAT_PERIOD, default 5_000_000, clocks between auto-repeat pulses (0.2 s at 25 MHz).
REQ-003 i_Clk  input  1  single system clock; all logic on its rising edge.
REQ-004 i_Reset  input  1  synchronous, active-high reset.
REQ-005 i_Switches  input  4  debounced, clock-synchronous buttons: [0]=Up, [1]=Down, [2]=Left, [3]=Right; 1=pressed.
REQ-006 o_Up_Mvt, o_Down_Mvt, o_Left_Mvt, o_Right_Mvt  output  1 each  one-cycle move pulses to the game logic.
REQ-007 o_Game_Start  output  1  one-cycle start pulse.
REQ-008 o_Busy  output  1  high in any state other than IDLE.

Function
REQ-009 States SHALL be IDLE, DELAY, REPEAT and LOCK.
REQ-010 All outputs SHALL be registered; a pulse SHALL assert on the cycle after the sampled input condition and last exactly one cycle.
REQ-011 At most one of the five pulse outputs SHALL be high in any cycle.
REQ-012 IDLE, i_Switches==4'b1111: pulse o_Game_Start, go to LOCK.
REQ-013 IDLE, any other nonzero i_Switches: latch the highest-priority pressed direction (Up>Down>Left>Right), pulse its output, clear the counter, go to DELAY.
REQ-014 DELAY: counter increments each cycle; on reaching REPEAT_DELAY-1 with the latched button still pressed, pulse the latched direction, clear the counter, go to REPEAT.
REQ-015 REPEAT: counter increments each cycle; on reaching REPEAT_PERIOD-1 with the latched button still pressed, pulse the latched direction, clear the counter, stay in REPEAT.
REQ-016 DELAY or REPEAT, latched button released: no pulse; go to IDLE if i_Switches==0, otherwise to LOCK.
REQ-017 DELAY or REPEAT, i_Switches==4'b1111: pulse o_Game_Start (this has priority over the release and timeout rules), go to LOCK.
REQ-018 In DELAY and REPEAT, pressing a non-latched direction SHALL neither change the latched direction nor produce a pulse.
REQ-019 LOCK: no pulses; go to IDLE on the first cycle i_Switches==0.
REQ-020 The counter width SHALL be $clog2 of the larger of REPEAT_DELAY and REPEAT_PERIOD; it SHALL never wrap, being cleared on every state transition.
REQ-021 Both parameters SHALL be at least 2; elaboration SHALL fail otherwise.

Reset
REQ-022 While i_Reset is high, the block SHALL set state=IDLE, counter=0, latched direction=Up, and all outputs=0 on the next clock edge.
REQ-023 Reset asserted mid-DELAY or mid-REPEAT SHALL abort without a pulse; buttons still held when reset is released SHALL be treated as a fresh press from IDLE.

Configuration
REQ-024 Macro FROG_MOVE_AUTOREPEAT_EN defined: behaviour as in REQ-014/015.
REQ-025 Macro FROG_MOVE_AUTOREPEAT_EN undefined: DELAY and REPEAT SHALL be removed along with the counter; after the initial pulse the block goes directly to LOCK, giving exactly one pulse per press. The REPEAT_* parameters remain declared but are unused.

Structure
REQ-026 The shared package SHALL hold the state encoding and the direction index constants (UP=0, DOWN=1, LEFT=2, RIGHT=3).
REQ-027 The counter with its terminal-count compare SHALL be one sub-module, repeat_timer, instantiated only when FROG_MOVE_AUTOREPEAT_EN is defined.

Verification (REPEAT_DELAY=10, REPEAT_PERIOD=4)
REQ-028 Reset, then Up held 30 cycles -> o_Up_Mvt pulses at cycles 1, 11, 15, 19, 23 and 27 after the press; release -> IDLE, o_Busy=0.
REQ-029 Left pressed, then Right added 2 cycles later and held -> only o_Left_Mvt pulses; release Left with Right still held -> LOCK, no pulse until all released.
REQ-030 All four pressed in the same cycle from IDLE -> exactly one o_Game_Start and no move pulse; held 50 cycles -> no further pulses.
REQ-031 Down and Right pressed together -> single o_Down_Mvt; with the macro undefined, held 30 cycles -> exactly one pulse.
REQ-032 Reset asserted at cycle 8 of a held Up press -> no pulse at cycle 11; Up still held at reset release -> o_Up_Mvt on the next cycle.
